// File: rtl/sti_deser_if.sv
// Serial-in / word-out bundle for sti_deser.
// The slave side is the deserializer; the master side is the serializer and the word consumer.
interface sti_deser_if #(
    parameter int CNT_W = 16
);
    logic             si_data;
    logic             si_valid;
    logic [1:0]       cfg_length;
    logic             cfg_msb;
    logic [31:0]      word_data;
    logic [1:0]       word_len;
    logic             word_valid;
    logic             word_ready;
    logic             frame_err;
    logic             overflow;
    logic [CNT_W-1:0] word_count;

    modport master (
        output si_data, si_valid, cfg_length, cfg_msb, word_ready,
        input  word_data, word_len, word_valid, frame_err, overflow, word_count
    );

    modport slave (
        input  si_data, si_valid, cfg_length, cfg_msb, word_ready,
        output word_data, word_len, word_valid, frame_err, overflow, word_count
    );
endinterface

// File: rtl/sti_deser.sv
// Rebuilds 8/16/24/32-bit serial frames into right-justified words behind a small valid/ready FIFO.
// Defining STI_DESER_CNT_EN adds the completed-word counter; otherwise word_count is tied to 0.
module sti_deser #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    sti_deser_if.slave bus
);
    localparam int            AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   OCC_ONE  = 1;
    localparam logic [AW:0]   OCC_FULL = FIFO_DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = 1;

    typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

    state_e        state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [31:0]   shift_q, shift_d;
    logic [1:0]    len_q, len_d;
    logic          msb_q, msb_d;
    logic          frame_err_q, frame_err_d;
    logic [5:0]    frame_bits;
    logic [31:0]   shift_in;
    logic          push;

    logic [31:0]   mem_dat_q [FIFO_DEPTH];
    logic [1:0]    mem_len_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic          overflow_q, overflow_d;
    logic          fifo_empty, fifo_full, pop, push_ok;

    // MSB-first shifts toward the top so bit k ends at N-1-k; LSB-first drops bit k at index k.
    always_comb begin
        frame_bits = {1'b0, len_q, 3'b000} + 6'd8;
        shift_in   = msb_q ? {shift_q[30:0], bus.si_data}
                           : (shift_q | (32'(bus.si_data) << cnt_q[4:0]));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        len_d       = len_q;
        msb_d       = msb_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.si_valid) begin
                    len_d   = bus.cfg_length;
                    msb_d   = bus.cfg_msb;
                    shift_d = {31'b0, bus.si_data};
                    cnt_d   = 6'd1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.si_valid) begin
                    if (cnt_q + 6'd1 == frame_bits) begin
                        // count 0 in SHIFT means "between words": a following bit reuses the latched config
                        push    = 1'b1;
                        shift_d = '0;
                        cnt_d   = '0;
                    end else begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 6'd1;
                    end
                end else begin
                    frame_err_d = (cnt_q != 6'd0);
                    shift_d     = '0;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign fifo_empty = (occ_q == '0);
    assign fifo_full  = (occ_q == OCC_FULL);
    assign pop        = bus.word_ready && !fifo_empty;
    assign push_ok    = push && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d   = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        overflow_d = overflow_q || (push && !push_ok);
        occ_d      = occ_q;
        if (push_ok && !pop) begin
            occ_d = occ_q + OCC_ONE;
        end else if (pop && !push_ok) begin
            occ_d = occ_q - OCC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            len_q       <= '0;
            msb_q       <= 1'b0;
            frame_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_dat_q[i] <= '0;
                mem_len_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            len_q       <= len_d;
            msb_q       <= msb_d;
            frame_err_q <= frame_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            overflow_q  <= overflow_d;
            if (push_ok) begin
                mem_dat_q[wr_ptr_q] <= shift_in;
                mem_len_q[wr_ptr_q] <= len_q;
            end
        end
    end

    assign bus.word_data  = mem_dat_q[rd_ptr_q];
    assign bus.word_len   = mem_len_q[rd_ptr_q];
    assign bus.word_valid = !fifo_empty;
    assign bus.frame_err  = frame_err_q;
    assign bus.overflow   = overflow_q;

`ifdef STI_DESER_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    assign word_cnt_d = push_ok ? word_cnt_q + CNT_ONE : word_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign bus.word_count = word_cnt_q;
`else
    assign bus.word_count = '0;
`endif
endmodule

// File: tb/tb_sti_deser.sv
// Bench for sti_deser: vector table, hand-written corner sequences, then random frames vs a queue model.
module tb_sti_deser;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sti_deser_if #(.CNT_W(CW)) bus ();

    sti_deser #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  len;
        logic        msb;
        logic [31:0] serial;    // serial[k] is the k-th bit on the wire
        logic [31:0] exp_word;
    } vec_t;

    typedef struct {
        logic [1:0]  len;
        logic [31:0] data;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        exp_q[$];
    bit          mon_en   = 1'b0;
    bit          err_seen = 1'b0;
    int unsigned n_pushed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] exp_count(input int unsigned n);
`ifdef STI_DESER_CNT_EN
        return 32'(n % (1 << CW));
`else
        return 32'(n) & 32'd0;
`endif
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Reference: an N-bit frame read in wire order is the value itself (LSB first) or its bit reversal.
    function automatic logic [31:0] model_word(input logic [1:0] len, input logic msb, input logic [31:0] serial);
        int          n;
        logic [31:0] lo;
        n  = 8 * (int'(len) + 1);
        lo = (n == 32) ? serial : (serial & ((32'd1 << n) - 32'd1));
        if (msb) return rev32(lo) >> (32 - n);
        return lo;
    endfunction

    task automatic step();
        exp_t e;
        if (mon_en) begin
            bus.word_ready = ($urandom_range(0, 2) != 0);
            if (bus.word_valid && bus.word_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_word", 32'(bus.word_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_word_data", bus.word_data, e.data);
                    check("rnd_word_len", 32'(bus.word_len), 32'(e.len));
                end
            end
        end
        if (bus.frame_err) err_seen = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [1:0] len, input logic msb, input logic [31:0] serial, input bit real_cfg);
        int n;
        n = 8 * (int'(len) + 1);
        for (int k = 0; k < n; k++) begin
            bus.si_valid = 1'b1;
            bus.si_data  = serial[k];
            if (k == 0 && real_cfg) begin
                bus.cfg_length = len;
                bus.cfg_msb    = msb;
            end else begin
                bus.cfg_length = 2'($urandom);
                bus.cfg_msb    = 1'($urandom);
            end
            step();
        end
    endtask

    task automatic pulse_reset();
        reset        = 1'b1;
        bus.si_valid = 1'b0;
        step();
        reset        = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_word_data"},  bus.word_data, 32'd0);
        check({tag, "_word_len"},   32'(bus.word_len), 32'd0);
        check({tag, "_word_valid"}, 32'(bus.word_valid), 32'd0);
        check({tag, "_frame_err"},  32'(bus.frame_err), 32'd0);
        check({tag, "_overflow"},   32'(bus.overflow), 32'd0);
        check({tag, "_word_count"}, 32'(bus.word_count), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [8];
        logic [1:0]  rl, pl;
        logic        rm, pm;
        logic [31:0] rs;
        int          gap;
        bit          b2b;
        exp_t        e;

        vecs[0] = '{2'd0, 1'b1, 32'h0000004D, 32'h000000B2};
        vecs[1] = '{2'd1, 1'b0, 32'h0000A5C3, 32'h0000A5C3};
        vecs[2] = '{2'd1, 1'b1, 32'h0000A5C3, 32'h0000C3A5};
        vecs[3] = '{2'd2, 1'b0, 32'h00123456, 32'h00123456};
        vecs[4] = '{2'd2, 1'b1, 32'h000000FF, 32'h00FF0000};
        vecs[5] = '{2'd3, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[6] = '{2'd0, 1'b0, 32'h00000080, 32'h00000080};
        vecs[7] = '{2'd3, 1'b1, 32'h00000001, 32'h80000000};

        reset          = 1'b1;
        bus.si_valid   = 1'b0;
        bus.si_data    = 1'b0;
        bus.cfg_length = 2'd0;
        bus.cfg_msb    = 1'b0;
        bus.word_ready = 1'b0;
        @(posedge clk); #1;
        step();
        reset = 1'b0;
        check_reset_state("rst");

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].len, vecs[i].msb, vecs[i].serial, 1'b1);
            bus.si_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), 32'(bus.word_valid), 32'd1);
            check($sformatf("vec%0d_data", i), bus.word_data, vecs[i].exp_word);
            check($sformatf("vec%0d_len", i), 32'(bus.word_len), 32'(vecs[i].len));
            bus.word_ready = 1'b1;
            step();
            bus.word_ready = 1'b0;
            check($sformatf("vec%0d_empty", i), 32'(bus.word_valid), 32'd0);
            check($sformatf("vec%0d_no_err", i), 32'(bus.frame_err), 32'd0);
        end

        // Two 32-bit words back to back; config inputs wander during the second word.
        err_seen = 1'b0;
        send_frame(2'd3, 1'b1, rev32(32'h89ABCDEF), 1'b1);
        send_frame(2'd3, 1'b1, rev32(32'h01234567), 1'b0);
        bus.si_valid = 1'b0;
        check("b2b_first_data", bus.word_data, 32'h89ABCDEF);
        bus.word_ready = 1'b1;
        step();
        check("b2b_second_data", bus.word_data, 32'h01234567);
        check("b2b_second_len", 32'(bus.word_len), 32'd3);
        step();
        bus.word_ready = 1'b0;
        check("b2b_drained", 32'(bus.word_valid), 32'd0);
        check("b2b_no_frame_err", 32'(err_seen), 32'd0);

        // 24-bit frame cut after 10 bits.
        for (int k = 0; k < 10; k++) begin
            bus.si_valid   = 1'b1;
            bus.si_data    = 1'($urandom);
            bus.cfg_length = (k == 0) ? 2'd2 : 2'($urandom);
            step();
        end
        bus.si_valid = 1'b0;
        step();
        check("short_frame_err", 32'(bus.frame_err), 32'd1);
        check("short_fifo_empty", 32'(bus.word_valid), 32'd0);
        step();
        check("short_err_pulse_end", 32'(bus.frame_err), 32'd0);
        send_frame(2'd0, 1'b0, 32'h0000005A, 1'b1);
        bus.si_valid = 1'b0;
        check("short_recover_data", bus.word_data, 32'h0000005A);
        bus.word_ready = 1'b1;
        step();
        bus.word_ready = 1'b0;

        // Overflow: five words into a four-entry FIFO with no consumer.
        pulse_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            send_frame(2'd0, 1'b0, 32'h11 * (i + 1), 1'b1);
            bus.si_valid = 1'b0;
            step();
        end
        check("ovf_sticky", 32'(bus.overflow), 32'd1);
        check("ovf_word_count", 32'(bus.word_count), exp_count(DEPTH));
        bus.word_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("ovf_drain%0d_valid", i), 32'(bus.word_valid), 32'd1);
            check($sformatf("ovf_drain%0d_data", i), bus.word_data, 32'h11 * (i + 1));
            step();
        end
        bus.word_ready = 1'b0;
        check("ovf_drained", 32'(bus.word_valid), 32'd0);
        check("ovf_still_set", 32'(bus.overflow), 32'd1);

        // Reset with two words queued and a third partly received.
        send_frame(2'd1, 1'b0, 32'h0000BEEF, 1'b1);
        send_frame(2'd1, 1'b0, 32'h00001234, 1'b0);
        bus.si_valid = 1'b0;
        step();
        check("midrst_count_before", 32'(bus.word_count), exp_count(DEPTH + 2));
        for (int k = 0; k < 4; k++) begin
            bus.si_valid = 1'b1;
            bus.si_data  = 1'b1;
            step();
        end
        pulse_reset();
        check_reset_state("midrst");
        step();
        check("midrst_no_err", 32'(bus.frame_err), 32'd0);
        check("midrst_still_empty", 32'(bus.word_valid), 32'd0);

        // Random frames with random gaps, back-to-back words and a random consumer.
        err_seen = 1'b0;
        mon_en   = 1'b1;
        n_pushed = 0;
        pl       = 2'd0;
        pm       = 1'b0;
        for (int f = 0; f < 80; f++) begin
            gap = $urandom_range(0, 3);
            b2b = (f > 0) && (gap == 0);
            if (b2b) begin
                rl = pl;
                rm = pm;
            end else begin
                rl = 2'($urandom);
                rm = 1'($urandom);
            end
            for (int g = 0; g < gap; g++) begin
                bus.si_valid = 1'b0;
                step();
            end
            rs     = $urandom;
            e.len  = rl;
            e.data = model_word(rl, rm, rs);
            exp_q.push_back(e);
            n_pushed++;
            send_frame(rl, rm, rs, !b2b);
            pl = rl;
            pm = rm;
        end
        bus.si_valid = 1'b0;
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) step();
        mon_en = 1'b0;
        check("rnd_all_words_seen", 32'(exp_q.size()), 32'd0);
        check("rnd_no_frame_err", 32'(err_seen), 32'd0);
        check("rnd_no_overflow", 32'(bus.overflow), 32'd0);
        check("rnd_word_count", 32'(bus.word_count), exp_count(n_pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
